// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Brief  : Shared sizing constants and FSM state encoding for ram8_bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_load.sv
// ============================================================================
// Module : reg_load
// Brief  : WIDTH-bit storage register with load enable and async active-low reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_load
    import ram_pkg::*;
#(
    parameter int WIDTH = ram_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ram8_bank.sv
// ============================================================================
// Module : ram8_bank
// Brief  : Small register-file bank with per-word writes and a sequenced clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram8_bank
    import ram_pkg::*;
#(
    parameter int WIDTH = ram_pkg::WIDTH,
    parameter int DEPTH = ram_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            data_in,
    input  logic [$clog2(DEPTH)-1:0]    address,
    input  logic                        load,
    input  logic                        clear_req,
    output logic [DEPTH-1:0][WIDTH-1:0] regs_out,
    output logic                        busy,
    output logic                        clear_done,
    output logic                        load_dropped
);

    localparam int                 ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_clear_done;
    logic              r_load_dropped;

    logic [DEPTH-1:0]  w_we;
    logic [WIDTH-1:0]  w_wdata;

    // The clear sequencer and the write port share each word's single load
    // enable; data is forced to zero while clearing.
    always_comb begin
        w_we    = '0;
        w_wdata = (r_state == CLEAR) ? '0 : data_in;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_state == CLEAR) begin
                w_we[k] = (r_idx == ADDR_W'(k));
            end else begin
                w_we[k] = load && (address == ADDR_W'(k));
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_word
            reg_load #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_we[g]),
                .d     (w_wdata),
                .q     (regs_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_busy         <= 1'b0;
            r_clear_done   <= 1'b0;
            r_load_dropped <= 1'b0;
        end else begin
            r_clear_done   <= 1'b0;
            r_load_dropped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state <= CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_load_dropped <= load;
                    // clear_req is deliberately not looked at here: no restart, no extension.
                    if (r_idx == c_LAST) begin
                        r_state      <= IDLE;
                        r_idx        <= '0;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign clear_done   = r_clear_done;
    assign load_dropped = r_load_dropped;

endmodule

`default_nettype wire
